// File: rtl/life_window_gen.sv
// life_window_gen: streaming 3x3 neighborhood generator with zero-padded borders.
// Revision 1.0
`default_nettype none

module life_window_gen #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic [8:0] neighbors,
    input  logic       out_ready,
    output logic       out_last
);

    localparam int HIST_LEN = 2 * WIDTH + 3;
    localparam int CELLS    = WIDTH * HEIGHT;
    localparam int XW       = $clog2(WIDTH);
    localparam int YW       = $clog2(HEIGHT);
    localparam int IW       = $clog2(CELLS);
    localparam int FW       = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [HIST_LEN-1:0]   hist, hist_next;
    logic [IW-1:0]         in_idx;
    logic [FW-1:0]         flush_cnt;
    logic [XW-1:0]         ox;
    logic [YW-1:0]         oy;

    logic       slot_free, accept, flush_push, push, push_bit, produce, at_last;
    logic [8:0] win;

    always_comb begin
        slot_free  = !out_valid || out_ready;
        in_ready   = (state != FLUSH) && slot_free;
        accept     = in_valid && in_ready;
        flush_push = (state == FLUSH) && slot_free;
        push       = accept || flush_push;
        push_bit   = accept ? in_bit : 1'b0;
        hist_next  = {hist[HIST_LEN-2:0], push_bit};
        produce    = push && (state != FILL);
        at_last    = (ox == XW'(WIDTH - 1)) && (oy == YW'(HEIGHT - 1));
    end

    // hist_next[j] holds the cell pushed j steps ago; the centre lags by WIDTH+1.
    always_comb begin
        win[0] = hist_next[2*WIDTH+2];
        win[1] = hist_next[2*WIDTH+1];
        win[2] = hist_next[2*WIDTH];
        win[3] = hist_next[WIDTH+2];
        win[4] = hist_next[WIDTH+1];
        win[5] = hist_next[WIDTH];
        win[6] = hist_next[2];
        win[7] = hist_next[1];
        win[8] = hist_next[0];
        if (ox == '0) begin
            win[0] = 1'b0;
            win[3] = 1'b0;
            win[6] = 1'b0;
        end
        if (ox == XW'(WIDTH - 1)) begin
            win[2] = 1'b0;
            win[5] = 1'b0;
            win[8] = 1'b0;
        end
        if (oy == '0)                win[2:0] = 3'b000;
        if (oy == YW'(HEIGHT - 1))   win[8:6] = 3'b000;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && in_idx == IW'(WIDTH))         state_next = STREAM;
            STREAM:  if (accept && in_idx == IW'(CELLS - 1))     state_next = FLUSH;
            FLUSH:   if (flush_push && flush_cnt == FW'(WIDTH))  state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            hist      <= '0;
            in_idx    <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            if (push)
                hist <= hist_next;
            if (accept)
                in_idx <= (in_idx == IW'(CELLS - 1)) ? '0 : in_idx + IW'(1);
            if (flush_push)
                flush_cnt <= (flush_cnt == FW'(WIDTH)) ? '0 : flush_cnt + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            neighbors <= 9'h000;
            out_last  <= 1'b0;
            ox        <= '0;
            oy        <= '0;
        end else if (produce) begin
            out_valid <= 1'b1;
            neighbors <= win;
            out_last  <= at_last;
            if (ox == XW'(WIDTH - 1)) begin
                ox <= '0;
                oy <= (oy == YW'(HEIGHT - 1)) ? '0 : oy + YW'(1);
            end else begin
                ox <= ox + XW'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

`default_nettype wire
